// File: rtl/amber_imem_loader_if.sv
// Byte-stream and imem-write bundle for the amber boot loader.
// Handshake: a byte moves on a rising edge where iw_byte_valid and
// ow_byte_ready are both high; the source holds iw_byte stable while valid
// is high and not yet accepted, and the loader may drop ready at any time.
interface amber_imem_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24
);
  logic [7:0]        iw_byte;
  logic              iw_byte_valid;
  logic              ow_byte_ready;
  logic              ow_imem_we;
  logic [ADDR_W-1:0] ow_imem_addr;
  logic [DATA_W-1:0] ow_imem_wdata;
  logic              ow_core_rst;
  logic              ow_done;
  logic              ow_err;

  // Stream source / system side.
  modport master (
    output iw_byte, iw_byte_valid,
    input  ow_byte_ready, ow_imem_we, ow_imem_addr, ow_imem_wdata,
    input  ow_core_rst, ow_done, ow_err
  );

  // Loader side.
  modport slave (
    input  iw_byte, iw_byte_valid,
    output ow_byte_ready, ow_imem_we, ow_imem_addr, ow_imem_wdata,
    output ow_core_rst, ow_done, ow_err
  );
endinterface

// File: rtl/amber_imem_loader.sv
// Boot-time loader: takes a 3-byte big-endian word count N followed by N
// big-endian 24-bit words and writes them to imem addresses 0..N-1, holding
// the amber core in reset until the final word has landed.
module amber_imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24
) (
  input  logic       iw_clk,
  input  logic       iw_rst_n,
  input  logic       iw_restart,
  amber_imem_loader_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [23:0] DEPTH = 24'(2 ** ADDR_W);

  state_t            state;
  logic [1:0]        phase;
  logic [15:0]       hi_bytes;   // bytes captured at phases 0 and 1
  logic [ADDR_W:0]   remaining;  // one extra bit so a full-depth count fits
  logic [ADDR_W-1:0] addr_cnt;
  logic [23:0]       word;
  logic              xfer;
  logic              last_byte;

  // Ready is purely a function of state; restart blocks acceptance outright.
  assign bus.ow_byte_ready = ((state == ST_HDR) || (state == ST_DATA)) && !iw_restart;
  assign xfer      = bus.iw_byte_valid && bus.ow_byte_ready;
  assign last_byte = xfer && (phase == 2'd2);
  assign word      = {hi_bytes, bus.iw_byte};
  assign dbg_state = state;

  // Single FSM: byte assembly, header decode, imem writes and status flags.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state             <= ST_HDR;
      phase             <= 2'd0;
      hi_bytes          <= 16'd0;
      remaining         <= '0;
      addr_cnt          <= '0;
      bus.ow_imem_we    <= 1'b0;
      bus.ow_imem_addr  <= '0;
      bus.ow_imem_wdata <= '0;
      bus.ow_core_rst   <= 1'b1;
      bus.ow_done       <= 1'b0;
      bus.ow_err        <= 1'b0;
    end else if (iw_restart) begin
      // A write strobe already on the outputs this cycle still lands; only
      // future activity is cancelled.
      state           <= ST_HDR;
      phase           <= 2'd0;
      hi_bytes        <= 16'd0;
      remaining       <= '0;
      addr_cnt        <= '0;
      bus.ow_imem_we  <= 1'b0;
      bus.ow_core_rst <= 1'b1;
      bus.ow_done     <= 1'b0;
      bus.ow_err      <= 1'b0;
    end else begin
      bus.ow_imem_we <= 1'b0;
      if (xfer) begin
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        if (phase == 2'd0) hi_bytes[15:8] <= bus.iw_byte;
        if (phase == 2'd1) hi_bytes[7:0]  <= bus.iw_byte;
      end
      case (state)
        ST_HDR: begin
          if (last_byte) begin
            if (word == 24'd0) begin
              state       <= ST_DONE;
              bus.ow_done <= 1'b1;
            end else if (word > DEPTH) begin
              state      <= ST_ERR;
              bus.ow_err <= 1'b1;
            end else begin
              state     <= ST_DATA;
              remaining <= word[ADDR_W:0];
              addr_cnt  <= '0;
            end
          end
        end
        ST_DATA: begin
          if (last_byte) begin
            bus.ow_imem_we    <= 1'b1;
            bus.ow_imem_addr  <= addr_cnt;
            bus.ow_imem_wdata <= DATA_W'(word);
            addr_cnt          <= addr_cnt + ADDR_W'(1);
            remaining         <= remaining - (ADDR_W + 1)'(1);
            // The final write and the move to DONE share an edge, so the
            // core is released one cycle after the last strobe.
            if (remaining == (ADDR_W + 1)'(1)) begin
              state       <= ST_DONE;
              bus.ow_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          bus.ow_core_rst <= 1'b0;
        end
        default: begin
          // ST_ERR: park with the core held in reset until restart.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amber_imem_loader.sv
// Bench for amber_imem_loader: stream driver tasks, an imem-write scoreboard
// fed from the driver, a header table, and hand-written restart/reset cases.
module tb_amber_imem_loader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  amber_imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  amber_imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .iw_clk    (clk),
    .iw_rst_n  (rst_n),
    .iw_restart(restart),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int total   = 0;
  int bad     = 0;
  int wr_cnt  = 0;
  int exp_cnt = 0;
  int m_addr  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every imem strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst_n === 1'b1 && bus.ow_imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 bus.ow_imem_addr, bus.ow_imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("imem_write", {bus.ow_imem_addr, bus.ow_imem_wdata}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.iw_byte_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      chk("ready_idle", bus.ow_byte_ready, 1);
      @(posedge clk); #1;
    end
    bus.iw_byte       = b;
    bus.iw_byte_valid = 1'b1;
    @(negedge clk);
    chk("byte_ready", bus.ow_byte_ready, 1);
    @(posedge clk); #1;
    bus.iw_byte_valid = 1'b0;
  endtask

  task automatic send_header(input logic [23:0] n, input int maxgap);
    send_byte(n[23:16], $urandom_range(0, maxgap));
    send_byte(n[15:8],  $urandom_range(0, maxgap));
    send_byte(n[7:0],   $urandom_range(0, maxgap));
    m_addr = 0;
  endtask

  // Pushes the expected write, then checks the strobe 1 cycle after byte 3.
  task automatic send_word(input logic [23:0] w, input int maxgap);
    exp_q.push_back({ADDR_W'(m_addr), w});
    exp_cnt++;
    m_addr++;
    send_byte(w[23:16], $urandom_range(0, maxgap));
    send_byte(w[15:8],  $urandom_range(0, maxgap));
    send_byte(w[7:0],   $urandom_range(0, maxgap));
    chk("write_latency", bus.ow_imem_we, 1);
  endtask

  // Called in the cycle carrying the final write strobe.
  task automatic check_done_seq();
    chk("core_rst_in_last_write", bus.ow_core_rst, 1);
    chk("done_with_last_write", bus.ow_done, 1);
    @(posedge clk); #1;
    chk("core_rst_release", bus.ow_core_rst, 0);
    chk("done_sticky", bus.ow_done, 1);
    chk("ready_in_done", bus.ow_byte_ready, 0);
  endtask

  task automatic do_restart(input logic offer);
    restart           = 1'b1;
    bus.iw_byte       = 8'hAA;
    bus.iw_byte_valid = offer;
    @(negedge clk);
    chk("ready_in_restart", bus.ow_byte_ready, 0);
    @(posedge clk); #1;
    restart           = 1'b0;
    bus.iw_byte_valid = 1'b0;
    chk("restart_done_clr", bus.ow_done, 0);
    chk("restart_err_clr", bus.ow_err, 0);
    chk("restart_core_rst", bus.ow_core_rst, 1);
    m_addr = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_we", bus.ow_imem_we, 0);
    chk("rst_addr", bus.ow_imem_addr, 0);
    chk("rst_wdata", bus.ow_imem_wdata, 0);
    chk("rst_core_rst", bus.ow_core_rst, 1);
    chk("rst_done", bus.ow_done, 0);
    chk("rst_err", bus.ow_err, 0);
    chk("rst_ready", bus.ow_byte_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [23:0] hdr;
    logic        done;
    logic        err;
    logic        ready;
    logic        core_rst;
  } hdr_vec_t;

  hdr_vec_t    tbl[6];
  logic [23:0] img[5];

  initial begin
    int w0;
    img[0] = 24'h301000; img[1] = 24'h721003; img[2] = 24'h302001;
    img[3] = 24'h303002; img[4] = 24'hA00000;

    tbl[0] = '{24'h000000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{24'h000001, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{24'h000100, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{24'h001000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{24'h001001, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};

    restart           = 1'b0;
    bus.iw_byte       = 8'h00;
    bus.iw_byte_valid = 1'b0;
    rst_n             = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reference program, back-to-back bytes.
    send_header(24'd5, 0);
    for (int i = 0; i < 5; i++) send_word(img[i], 0);
    check_done_seq();

    // Same program with 0..3 idle cycles between bytes.
    do_restart(1'b0);
    send_header(24'd5, 3);
    for (int i = 0; i < 5; i++) send_word(img[i], 3);
    check_done_seq();

    // Header decode table: status two cycles after the third header byte.
    for (int i = 0; i < 6; i++) begin
      do_restart(1'b0);
      w0 = wr_cnt;
      send_header(tbl[i].hdr, 0);
      @(posedge clk); #1;
      chk("tbl_done", bus.ow_done, tbl[i].done);
      chk("tbl_err", bus.ow_err, tbl[i].err);
      chk("tbl_ready", bus.ow_byte_ready, tbl[i].ready);
      chk("tbl_core_rst", bus.ow_core_rst, tbl[i].core_rst);
      chk("tbl_no_write", 64'(wr_cnt - w0), 0);
    end

    // Full-depth image: last write lands at the top address.
    do_restart(1'b0);
    send_header(24'(DEPTH), 0);
    for (int i = 0; i < DEPTH; i++) send_word(24'($urandom), 0);
    chk("full_last_addr", bus.ow_imem_addr, DEPTH - 1);
    check_done_seq();

    // Restart during the second write strobe, with a byte offered.
    do_restart(1'b0);
    send_header(24'd5, 0);
    send_word(img[0], 0);
    send_word(img[1], 0);
    chk("pending_we_addr", bus.ow_imem_addr, 1);
    do_restart(1'b1);
    send_header(24'd2, 1);
    send_word(24'h123456, 1);
    send_word(24'h654321, 1);
    check_done_seq();

    // Async reset in the middle of a word (phase 1).
    do_restart(1'b0);
    send_header(24'd3, 0);
    send_word(24'h5A5A5A, 0);
    send_byte(8'h12, 0);
    #3 rst_n = 1'b0;
    #1 check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_header(24'd1, 0);
    send_word(24'h0ABCDE, 0);
    check_done_seq();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("write_count", wr_cnt, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amber_imem_loader.md
Name: amber_imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the amber core's instruction memory (u_imem).
- Accepts a byte stream (valid/ready), assembles big-endian 24-bit instruction words and writes them to consecutive imem addresses starting at 0.
- Holds the core in reset until the load completes, replacing direct r_mem preloading for both bench and board bring-up.

Parameters:
- ADDR_W, 12, imem word-address width; depth = 2^ADDR_W words.
- DATA_W, 24, instruction width; fixed at 3 bytes and not overridable in practice.

Ports:
- iw_clk  in  1  clock; all logic is rising-edge.
- iw_rst_n  in  1  asynchronous, active-low reset.
- iw_restart  in  1  synchronous pulse; aborts and restarts the load from the header.
- iw_byte  in  8  stream byte.
- iw_byte_valid  in  1  stream byte valid.
- ow_byte_ready  out  1  loader accepts a byte this cycle.
- ow_imem_we  out  1  imem write strobe, one cycle per word.
- ow_imem_addr  out  ADDR_W  imem write address.
- ow_imem_wdata  out  DATA_W  imem write data.
- ow_core_rst  out  1  active-high reset to the amber core (drives its iw_rst).
- ow_done  out  1  load complete; sticky until restart or reset.
- ow_err  out  1  header word count exceeds depth; sticky until restart or reset.

Behaviour:
- Reset, on asynchronous assertion of iw_rst_n:
  - state=HDR, byte phase=0, word count=0, address counter=0.
  - ow_imem_we=0, ow_imem_addr=0, ow_imem_wdata=0.
  - ow_core_rst=1, ow_done=0, ow_err=0.
- A byte transfer occurs when iw_byte_valid && ow_byte_ready. ow_byte_ready is combinational from state: 1 in HDR and DATA, 0 in DONE and ERR, and forced 0 in any cycle where iw_restart=1.
- Byte assembly:
  - Phase counter runs 0,1,2 and wraps to 0.
  - Phase 0 → bits 23:16, phase 1 → bits 15:8, phase 2 → bits 7:0.
  - Gaps (valid low) hold the phase and the partial word.
- HDR state:
  - The first 3 bytes form N, a 24-bit word count.
  - On the third byte:
    - N=0 → DONE.
    - N > 2^ADDR_W → ERR.
    - Otherwise → DATA, with remaining count = N and address counter = 0.
- DATA state:
  - On each third byte, the next cycle has ow_imem_we=1, ow_imem_addr = address counter, ow_imem_wdata = the assembled word. The write latency is 1 cycle after the accepting edge.
  - Address counter and remaining count then update (+1 and −1).
  - When remaining count reaches 0 with that write, go to DONE in the same edge that issues the final ow_imem_we.
  - The address counter never wraps: N ≤ 2^ADDR_W is guaranteed by the HDR check.
- DONE state:
  - ow_done=1.
  - ow_core_rst deasserts on the cycle after the final write strobe, so the last word lands before the core fetches.
  - For N=0, ow_core_rst deasserts the cycle after DONE is entered.
  - Stays in DONE until restart or reset.
- ERR state:
  - ow_err=1, ow_core_rst stays 1, no writes are issued, and the loader stays in ERR until restart or reset.
- ow_imem_we is 0 in every cycle other than the write cycle. ow_imem_addr and ow_imem_wdata hold their last values.
- iw_restart, from any state:
  - Next state is HDR.
  - Phase, count and address are cleared.
  - ow_core_rst=1, ow_done=0, ow_err=0.
  - A pending write already registered still completes that cycle.
  - A byte presented in the same cycle as restart is not accepted.
- Reset mid-load: async return to reset values. A partially loaded image remains in imem and is not erased.

Test Plan:
- Stream 00 00 05 | 30 10 00 | 72 10 03 | 30 20 01 | 30 30 02 | A0 00 00 with valid always high:
  - Writes (0,301000) (1,721003) (2,302001) (3,303002) (4,A00000), each 1 cycle after its third byte.
  - ow_core_rst falls 1 cycle after the addr-4 write; ow_done=1.
  - The core then ends with DR1=0, DR2=0, DR3=2.
- Same stream with 0–3 random idle cycles between bytes → identical write sequence and final core state; ow_byte_ready stays 1 until DONE.
- Header 00 00 00 → no ow_imem_we pulse; ow_done=1 and ow_core_rst=0 within 2 cycles of the third byte.
- ADDR_W=12, header 00 10 01 (4097) → ow_err=1, ow_byte_ready=0, ow_core_rst stays 1, zero writes. Header 00 10 00 (4096) is accepted and the last write goes to addr FFF.
- Restart after 2 of 5 words:
  - ow_done/ow_err clear and ow_core_rst=1.
  - A byte offered in the restart cycle is ignored.
  - A fresh 2-word image writes addrs 0 and 1 and then reaches DONE.
- Drop iw_rst_n asynchronously mid-word (phase 1):
  - All outputs take their reset values immediately.
  - After release, a new header is required, and the partial byte is discarded.
